// File: rtl/pci_target_buffer_if.sv
// Control/handshake signals of the PCI-like local bus. All are active-low except cbe.
// The shared AD bus stays a plain inout on the target.
interface pci_target_buffer_if;
  logic       frame;
  logic [3:0] cbe;
  logic       irdy;
  logic       trdy;

  modport master (
    output frame,
    output cbe,
    output irdy,
    input  trdy
  );

  modport slave (
    input  frame,
    input  cbe,
    input  irdy,
    output trdy
  );
endinterface

// File: rtl/pci_target_buffer.sv
// Simplified PCI-style target: write bursts fill a word buffer, and read bursts replay
// the words stored by the most recent write burst onto the shared AD bus.
module pci_target_buffer #(
  parameter int         DEPTH     = 8,
  parameter int         DATA_W    = 32,
  parameter logic [3:0] CMD_WRITE = 4'b0111,
  parameter logic [3:0] CMD_READ  = 4'b0110
) (
  input  logic                clk,
  input  logic                rst,
  pci_target_buffer_if.slave  bus,
  inout  wire  [DATA_W-1:0]   ad,
  output logic [DATA_W-1:0]   o_addr,
  output logic [3:0]          o_cmd
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_TURN,
    S_READ,
    S_IGNORE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_trdy;
  logic                w_trdy_nxt;
  logic [IDX_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_addr;
  logic [3:0]          r_cmd;
  logic [DATA_W-1:0]   r_buf [DEPTH];

  logic                w_xfer;
  logic                w_end;
  logic                w_rd_drive;
  logic [PTR_W-1:0]    w_count_inc;
  logic [PTR_W-1:0]    w_rd_inc;
  logic                w_latch;
  logic                w_wr_start;
  logic                w_rd_start;
  logic                w_store;
  logic                w_rd_adv;

  assign w_xfer      = !bus.irdy && !r_trdy;
  assign w_end       = bus.frame && bus.irdy;
  assign w_count_inc = r_count + 1'b1;
  assign w_rd_inc    = r_rd_ptr + 1'b1;

  // Drive AD only while words remain to be read; TURN keeps it released for a cycle.
  assign w_rd_drive  = (r_state == S_READ) && (r_rd_ptr < r_count);
  assign ad          = w_rd_drive ? r_buf[r_rd_ptr[IDX_W-1:0]] : {DATA_W{1'bz}};

  assign bus.trdy    = r_trdy;
  assign o_addr      = r_addr;
  assign o_cmd       = r_cmd;

  always_comb begin
    w_state_nxt = r_state;
    w_trdy_nxt  = r_trdy;
    w_latch     = 1'b0;
    w_wr_start  = 1'b0;
    w_rd_start  = 1'b0;
    w_store     = 1'b0;
    w_rd_adv    = 1'b0;
    if (r_state == S_IDLE) begin
      w_trdy_nxt = 1'b1;
      if (!bus.frame) begin
        w_latch = 1'b1;
        if (bus.cbe == CMD_WRITE) begin
          w_state_nxt = S_WRITE;
          w_trdy_nxt  = 1'b0;
          w_wr_start  = 1'b1;
        end else if (bus.cbe == CMD_READ) begin
          w_state_nxt = S_TURN;
          w_rd_start  = 1'b1;
        end else begin
          w_state_nxt = S_IGNORE;
        end
      end
    end else if (w_end) begin
      w_state_nxt = S_IDLE;
      w_trdy_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_WRITE: begin
          if (w_xfer) begin
            w_store = 1'b1;
            if (w_count_inc == FULL) w_trdy_nxt = 1'b1;
          end
        end
        S_TURN: begin
          w_state_nxt = S_READ;
          w_trdy_nxt  = (r_count == '0);
        end
        S_READ: begin
          if (w_xfer) begin
            w_rd_adv = 1'b1;
            if (w_rd_inc == r_count) w_trdy_nxt = 1'b1;
          end
        end
        default: w_trdy_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_trdy   <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_cmd    <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_trdy  <= w_trdy_nxt;
      if (w_latch) begin
        r_addr <= ad;
        r_cmd  <= bus.cbe;
      end
      if (w_wr_start) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end
      if (w_rd_start) r_rd_ptr <= '0;
      if (w_store) begin
        r_buf[r_wr_ptr] <= ad;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_count         <= w_count_inc;
      end
      if (w_rd_adv) r_rd_ptr <= w_rd_inc;
    end
  end

endmodule

// File: tb/tb_pci_target_buffer.sv
// Bench for pci_target_buffer: directed bursts, read data checked by a queue-based monitor.
module tb_pci_target_buffer;
  localparam int DEPTH = 8;
  localparam logic [31:0] REL = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pci_target_buffer_if bus();
  wire  [31:0] ad;
  logic [31:0] m_ad;
  logic        m_oe;
  logic [31:0] o_addr;
  logic [3:0]  o_cmd;

  assign ad = m_oe ? m_ad : 32'hzzzz_zzzz;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (ad[g]);
  end

  pci_target_buffer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .ad     (ad),
    .o_addr (o_addr),
    .o_cmd  (o_cmd)
  );

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [31:0] mon_e;
  logic [31:0] wdata [16];
  logic [31:0] rexp  [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read transfer seen on the bus must match the next queued word.
  always @(negedge clk) begin
    if (mon_en && !rst && !bus.irdy && !bus.trdy && !m_oe) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no transfer", ad);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", ad, mon_e);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int n, input logic [15:0] wmask);
    bus.frame = 1'b0; bus.cbe = 4'b0111; bus.irdy = 1'b1; m_oe = 1'b1; m_ad = addr;
    @(negedge clk); chk("wr_addr_trdy", bus.trdy, 1'b1);
    step();
    for (int i = 0; i < n; i++) begin
      if (wmask[i]) begin
        m_ad = wdata[i]; bus.irdy = 1'b1; bus.frame = 1'b0;
        @(negedge clk); chk("wr_wait_trdy", bus.trdy, (i < DEPTH) ? 1'b0 : 1'b1);
        step();
      end
      m_ad = wdata[i]; bus.irdy = 1'b0; bus.frame = (i == n - 1);
      @(negedge clk);
      chk("wr_trdy", bus.trdy, (i < DEPTH) ? 1'b0 : 1'b1);
      if (i == 0) begin
        chk("addr_latched", o_addr, addr);
        chk("cmd_latched", {28'd0, o_cmd}, 32'h7);
      end
      step();
    end
    bus.frame = 1'b1; bus.irdy = 1'b1; m_oe = 1'b0;
    @(negedge clk); chk("wr_end_trdy", bus.trdy, (n >= DEPTH) ? 1'b1 : 1'b0);
    step();
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input logic [15:0] rmask);
    bus.frame = 1'b0; bus.cbe = 4'b0110; bus.irdy = 1'b1; m_oe = 1'b1; m_ad = addr;
    @(negedge clk); chk("rd_addr_trdy", bus.trdy, 1'b1);
    step();
    m_oe = 1'b0; bus.irdy = 1'b0;
    @(negedge clk);
    chk("turn_trdy", bus.trdy, 1'b1);
    chk("turn_ad_z", ad, REL);
    step();
    if (n == 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("rd_empty_trdy", bus.trdy, 1'b1);
        chk("rd_empty_ad_z", ad, REL);
        step();
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (rmask[i]) begin
          bus.irdy = 1'b1; bus.frame = 1'b0;
          @(negedge clk);
          chk("rd_wait_trdy", bus.trdy, 1'b0);
          chk("rd_wait_hold", ad, rexp[i]);
          step();
        end
        exp_q.push_back(rexp[i]);
        bus.irdy = 1'b0; bus.frame = (i == n - 1);
        @(negedge clk); chk("rd_trdy", bus.trdy, 1'b0);
        step();
      end
    end
    bus.frame = 1'b1; bus.irdy = 1'b1;
    @(negedge clk);
    chk("rd_end_trdy", bus.trdy, 1'b1);
    chk("rd_end_ad_z", ad, REL);
    step();
  endtask

  task automatic do_ignore(input logic [31:0] addr);
    bus.frame = 1'b0; bus.cbe = 4'b0010; bus.irdy = 1'b1; m_oe = 1'b1; m_ad = addr;
    @(negedge clk); chk("ign_addr_trdy", bus.trdy, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      m_oe = 1'b0; bus.irdy = 1'b0; bus.frame = 1'b0;
      @(negedge clk);
      chk("ign_trdy", bus.trdy, 1'b1);
      chk("ign_ad_z", ad, REL);
      if (k == 0) chk("ign_cmd", {28'd0, o_cmd}, 32'h2);
      step();
    end
    bus.frame = 1'b1; bus.irdy = 1'b1;
    @(negedge clk); chk("ign_end_trdy", bus.trdy, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus.frame = 1'b1; bus.irdy = 1'b1; bus.cbe = 4'h0; m_oe = 1'b0; m_ad = '0;
    for (int k = 0; k < 2; k++) begin
      bus.frame = 1'($urandom_range(1));
      bus.irdy  = 1'($urandom_range(1));
      bus.cbe   = 4'($urandom_range(15));
      m_oe      = 1'b1;
      m_ad      = $urandom;
      step();
    end
    rst = 1'b0; bus.frame = 1'b1; bus.irdy = 1'b1; m_oe = 1'b0;
    @(negedge clk);
    chk("rst_trdy", bus.trdy, 1'b1);
    chk("rst_ad_z", ad, REL);
    chk("rst_addr", o_addr, 32'd0);
    mon_en = 1'b1;
    step();
    do_read(32'd0, 0, 16'h0);

    // Full burst with two master wait states, then replay.
    wdata[0] = 32'd1000; wdata[1] = 32'd133; wdata[2] = 32'd176; wdata[3] = 32'hAA;
    wdata[4] = 32'hBB;   wdata[5] = 32'hCC;  wdata[6] = 32'hDD;  wdata[7] = 32'hEE;
    do_write(32'd287, 8, 16'h0088);
    for (int i = 0; i < 8; i++) rexp[i] = wdata[i];
    do_read(32'd287, 8, 16'h0);

    // Overflow: only the first DEPTH words are kept.
    for (int i = 0; i < 10; i++) wdata[i] = 32'h100 + i;
    do_write(32'h40, 10, 16'h0);
    for (int i = 0; i < 8; i++) rexp[i] = 32'h100 + i;
    do_read(32'h40, 8, 16'h0);

    // Unsupported command leaves the buffer alone.
    do_ignore(32'h55);
    do_read(32'h40, 8, 16'h0);

    // Short burst with a read wait state.
    wdata[0] = 32'd5; wdata[1] = 32'd6; wdata[2] = 32'd7;
    do_write(32'h10, 3, 16'h0);
    rexp[0] = 32'd5; rexp[1] = 32'd6; rexp[2] = 32'd7;
    do_read(32'h10, 3, 16'h0002);

    // Reset in the middle of a write burst empties the buffer.
    bus.frame = 1'b0; bus.cbe = 4'b0111; bus.irdy = 1'b1; m_oe = 1'b1; m_ad = 32'h20;
    step();
    m_ad = 32'd9; bus.irdy = 1'b0;
    step();
    m_ad = 32'd10;
    step();
    rst = 1'b1; bus.frame = 1'b1; bus.irdy = 1'b1; m_oe = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_trdy", bus.trdy, 1'b1);
    chk("midrst_ad_z", ad, REL);
    step();
    do_read(32'h20, 0, 16'h0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
